// File: rtl/noc_echo_endpoint.sv
// noc_echo_endpoint
//   Stand-in for the NoC on a single compute tile. Every flit the tile emits
//   is buffered in a per-VC FIFO and sent back on the same VC. Head and single
//   flits get their header rewritten on the way in: dest <- old src,
//   src <- ECHO_ID.
//
//   Optional feature macro: OPTIMSOC_NOC_ECHO_CHECK_EN
//     When defined, per-VC receive framing is tracked and framing violations
//     also raise proto_err. Offending flits are still stored and echoed.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   in_flit/valid     flits from the tile (noc_out_*), per-VC valid
//   in_ready          per-VC ready back to the tile
//   out_flit/valid    echoed flits to the tile (noc_in_*), one-hot valid
//   out_ready         per-VC ready from the tile
//   rx_pkts, tx_pkts  wrapping counts of last/single flits received / sent
//   proto_err         sticky protocol-error flag

// Per-VC FIFO. Pointers carry one extra wrap bit to tell full from empty.
// Read data is the current head (show-ahead).
module noc_echo_fifo #(
   parameter int W     = 34,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module noc_echo_endpoint #(
   parameter int FLIT_WIDTH = 34,
   parameter int VCHANNELS  = 3,
   parameter int DEPTH      = 16,
   parameter int ECHO_ID    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLIT_WIDTH-1:0] in_flit,
   input  logic [VCHANNELS-1:0]  in_valid,
   output logic [VCHANNELS-1:0]  in_ready,
   output logic [FLIT_WIDTH-1:0] out_flit,
   output logic [VCHANNELS-1:0]  out_valid,
   input  logic [VCHANNELS-1:0]  out_ready,
   output logic [15:0]           rx_pkts,
   output logic [15:0]           tx_pkts,
   output logic                  proto_err
);
   localparam int VW     = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
   localparam int TYP_HI = FLIT_WIDTH - 1;  // set for last / single
   localparam int TYP_LO = FLIT_WIDTH - 2;  // set for head / single
   localparam int DEST_MSB = 31;
   localparam int SRC_MSB  = 23;
   localparam logic [4:0]    SRC_ID  = ECHO_ID[4:0];
   localparam logic [VW-1:0] LAST_VC = VW'(VCHANNELS - 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                               state;
   logic [VW-1:0]                        rr;
   logic [VW-1:0]                        cur;
   logic [VW-1:0]                        cand;
   logic [VW-1:0]                        sel;
   logic                                 run;
   logic                                 multi;
   logic                                 frame_err;
   logic                                 any_ne;
   logic                                 sel_valid;
   logic                                 hs;
   logic                                 hs_last;
   logic [VCHANNELS-1:0]                 full;
   logic [VCHANNELS-1:0]                 empty;
   logic [VCHANNELS-1:0]                 wr_en;
   logic [VCHANNELS-1:0]                 rd_en;
   logic [VCHANNELS-1:0][FLIT_WIDTH-1:0] head;
   logic [FLIT_WIDTH-1:0]                wr_data;
   int                                   idx;

   function automatic logic [VW-1:0] next_vc(input logic [VW-1:0] v);
      return (v == LAST_VC) ? '0 : v + VW'(1);
   endfunction

   // ---------------- receive ----------------
   // More than one valid bit: at least two ones <=> x & (x-1) nonzero.
   assign multi    = |(in_valid & (in_valid - VCHANNELS'(1)));
   // run holds ready low through reset and the first cycle after release.
   assign in_ready = run ? ~full : '0;
   assign wr_en    = multi ? '0 : (in_valid & in_ready);

   always_comb begin
      wr_data = in_flit;
      if (in_flit[TYP_LO]) begin
         wr_data[DEST_MSB -: 5] = in_flit[SRC_MSB -: 5];
         wr_data[SRC_MSB -: 5]  = SRC_ID;
      end
   end

   for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
      noc_echo_fifo #(
         .W     (FLIT_WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_en[v]),
         .wr_data (wr_data),
         .rd_en   (rd_en[v]),
         .rd_data (head[v]),
         .full    (full[v]),
         .empty   (empty[v])
      );
   end

`ifdef OPTIMSOC_NOC_ECHO_CHECK_EN
   logic [VCHANNELS-1:0] in_pkt;

   // head/single expects a closed packet, payload/last an open one:
   // violation exactly when the head-type bit equals the open bit.
   always_comb begin
      frame_err = 1'b0;
      for (int v = 0; v < VCHANNELS; v++)
         if (wr_en[v] && (in_flit[TYP_LO] == in_pkt[v])) frame_err = 1'b1;
   end

   // head and payload leave the packet open, last and single close it
   always_ff @(posedge clk) begin
      if (rst) in_pkt <= '0;
      else
         for (int v = 0; v < VCHANNELS; v++)
            if (wr_en[v]) in_pkt[v] <= !in_flit[TYP_HI];
   end
`else
   assign frame_err = 1'b0;
`endif

   // ---------------- transmit ----------------
   // First non-empty FIFO at or after rr, with wrap-around. Scanning from the
   // far end down lets the nearest hit win.
   always_comb begin
      cand = rr;
      idx  = 0;
      for (int i = VCHANNELS - 1; i >= 0; i--) begin
         idx = int'(rr) + i;
         if (idx >= VCHANNELS) idx = idx - VCHANNELS;
         if (!empty[idx]) cand = VW'(idx);
      end
   end

   assign any_ne = ~&empty;

   // The lock taken in IDLE is effective combinationally so a flit can be
   // offered in the first cycle its FIFO is non-empty.
   assign sel       = (state == LOCKED) ? cur : cand;
   assign sel_valid = ((state == LOCKED) || any_ne) && !empty[sel];
   assign out_flit  = sel_valid ? head[sel] : '0;
   assign hs        = sel_valid && out_ready[sel];
   assign hs_last   = hs && out_flit[TYP_HI];

   always_comb begin
      out_valid = '0;
      rd_en     = '0;
      if (sel_valid) out_valid[sel] = 1'b1;
      if (hs)        rd_en[sel]     = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cur   <= '0;
         rr    <= '0;
      end else begin
         case (state)
            IDLE: if (any_ne) begin
               cur <= cand;
               // a single flit sent right away never needs the lock
               if (hs_last) rr    <= next_vc(cand);
               else         state <= LOCKED;
            end
            LOCKED: if (hs_last) begin
               state <= IDLE;
               rr    <= next_vc(cur);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------- status ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         run       <= 1'b0;
         rx_pkts   <= '0;
         tx_pkts   <= '0;
         proto_err <= 1'b0;
      end else begin
         run <= 1'b1;
         if ((|wr_en) && in_flit[TYP_HI]) rx_pkts <= rx_pkts + 16'd1;
         if (hs_last)                     tx_pkts <= tx_pkts + 16'd1;
         if (multi || frame_err)          proto_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_noc_echo_endpoint.sv
// tb_noc_echo_endpoint
//   Directed bench for noc_echo_endpoint with default parameters
//   (34-bit flits, 3 VCs, depth 16, ECHO_ID 1). Expected flits are written
//   out by hand, including the header rewrite.
module tb_noc_echo_endpoint;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [33:0] in_flit = '0;
   logic [2:0]  in_valid = '0;
   logic [2:0]  in_ready;
   logic [33:0] out_flit;
   logic [2:0]  out_valid;
   logic [2:0]  out_ready = '0;
   logic [15:0] rx_pkts;
   logic [15:0] tx_pkts;
   logic        proto_err;

   int errors = 0;
   int checks = 0;

   noc_echo_endpoint dut (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (in_flit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_flit  (out_flit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rx_pkts   (rx_pkts),
      .tx_pkts   (tx_pkts),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int vc, input logic [33:0] f);
      in_flit  = f;
      in_valid = 3'b001 << vc;
      cyc();
      in_valid = '0;
      #1;
   endtask

   // hand-computed stimulus / expected flits
   localparam logic [33:0] S1    = {2'b11, 32'h0808_1234};  // dest1 src1 -> unchanged
   localparam logic [33:0] S2    = {2'b11, 32'h10F8_0000};  // dest2 src31
   localparam logic [33:0] S2_RW = {2'b11, 32'hF808_0000};
   localparam logic [33:0] H1    = {2'b01, 32'h0018_ABCD};  // dest0 src3
   localparam logic [33:0] H1_RW = {2'b01, 32'h1808_ABCD};
   localparam logic [33:0] L1    = {2'b10, 32'hDEAD_BEEF};
   localparam logic [33:0] S3    = {2'b11, 32'h0000_0000};  // src0
   localparam logic [33:0] S3_RW = {2'b11, 32'h0008_0000};
   localparam logic [33:0] A0    = {2'b01, 32'h0310_0001};  // class3 src2
   localparam logic [33:0] A0_RW = {2'b01, 32'h1308_0001};
   localparam logic [33:0] A1    = {2'b00, 32'hAAAA_0001};
   localparam logic [33:0] A2    = {2'b10, 32'hAAAA_0002};
   localparam logic [33:0] B0    = {2'b01, 32'h0020_0002};  // src4
   localparam logic [33:0] B0_RW = {2'b01, 32'h2008_0002};
   localparam logic [33:0] B1    = {2'b00, 32'hBBBB_0001};
   localparam logic [33:0] B2    = {2'b10, 32'hBBBB_0002};

   logic [33:0] got[$];
   logic [33:0] bp_exp[18];
   logic [33:0] rfl[6];
   int          rvc[6];
   logic [33:0] rr_exp[6];
   int          rr_vc[6];

   initial begin
      int  n;
      int  nxt;
      bit  done;
      bit  acc;
      bit  onehot_ok;

      // ---------------- reset ----------------
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("rst_in_ready%0d", i), in_ready, 3'b000);
         chk($sformatf("rst_out_valid%0d", i), out_valid, 3'b000);
      end
      chk("rst_out_flit", out_flit, '0);
      chk("rst_rx", rx_pkts, 0);
      chk("rst_tx", tx_pkts, 0);
      chk("rst_err", proto_err, 0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready0", in_ready, 3'b000);
      chk("rel_out_valid0", out_valid, 3'b000);
      cyc();
      chk("rel_in_ready1", in_ready, 3'b111);
      chk("rel_out_valid1", out_valid, 3'b000);

      // ---------------- single-flit echo ----------------
      out_ready = 3'b111;
      send(0, S1);
      chk("s1_valid", out_valid, 3'b001);
      chk("s1_flit", out_flit, S1);
      cyc();
      chk("s1_drained", out_valid, 3'b000);
      send(0, S2);
      chk("s2_valid", out_valid, 3'b001);
      chk("s2_flit", out_flit, S2_RW);
      cyc();
      chk("s_rx", rx_pkts, 2);
      chk("s_tx", tx_pkts, 2);

      // ---------------- back-pressure on VC1 ----------------
      out_ready = 3'b000;
      bp_exp[0] = H1_RW;
      for (int i = 0; i < 16; i++) bp_exp[i+1] = {2'b00, 32'hC0DE_0000 + i};
      bp_exp[17] = L1;
      send(1, H1);
      for (int i = 0; i < 15; i++) send(1, bp_exp[i+1]);
      chk("bp_full_ready", in_ready, 3'b101);
      chk("bp_hold_valid", out_valid, 3'b010);
      chk("bp_hold_flit", out_flit, H1_RW);
      cyc();
      chk("bp_stable_flit", out_flit, H1_RW);

      in_flit   = bp_exp[16];
      in_valid  = 3'b010;
      out_ready = 3'b111;
      nxt       = 16;
      done      = 1'b0;
      onehot_ok = 1'b1;
      for (int c = 0; c < 60 && !done; c++) begin
         #1;
         // full and being read: no bypass, ready still low
         if (c == 0) chk("bp_no_bypass", in_ready, 3'b101);
         acc = in_valid[1] && in_ready[1];
         if (out_valid != 3'b000) begin
            if (out_valid != 3'b010) onehot_ok = 1'b0;
            got.push_back(out_flit);
            if (out_flit == L1) done = 1'b1;
         end
         cyc();
         if (acc) begin
            nxt++;
            if (nxt == 17) in_flit = L1;
            else           in_valid = '0;
         end
      end
      chk("bp_done", done, 1);
      chk("bp_onehot", onehot_ok, 1);
      chk("bp_count", got.size(), 18);
      for (int i = 0; i < 18; i++)
         chk($sformatf("bp_flit%0d", i), (i < got.size()) ? got[i] : '1, bp_exp[i]);

      // ---------------- round-robin and lock ----------------
      // single on VC2 moves rr from 2 back to 0
      send(2, S3);
      chk("s3_valid", out_valid, 3'b100);
      chk("s3_flit", out_flit, S3_RW);
      cyc();
      out_ready = 3'b000;
      send(0, A0);
      send(2, B0);
      send(0, A1);
      send(2, B1);
      send(0, A2);
      send(2, B2);
      chk("rr_lock_valid", out_valid, 3'b001);
      chk("rr_lock_flit", out_flit, A0_RW);
      rr_exp = '{A0_RW, A1, A2, B0_RW, B1, B2};
      rr_vc  = '{0, 0, 0, 2, 2, 2};
      for (int i = 0; i < 6; i++) begin rfl[i] = '0; rvc[i] = -1; end
      out_ready = 3'b111;
      n = 0;
      for (int c = 0; c < 30 && n < 6; c++) begin
         #1;
         if (out_valid != 3'b000) begin
            case (out_valid)
               3'b001:  rvc[n] = 0;
               3'b010:  rvc[n] = 1;
               3'b100:  rvc[n] = 2;
               default: rvc[n] = 3;
            endcase
            rfl[n] = out_flit;
            n++;
         end
         cyc();
      end
      chk("rr_count", n, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rr_vc%0d", i), rvc[i], rr_vc[i]);
         chk($sformatf("rr_flit%0d", i), rfl[i], rr_exp[i]);
      end
      chk("rr_ptr", dut.rr, 0);
      chk("rr_rx", rx_pkts, 6);
      chk("rr_tx", tx_pkts, 6);

      // ---------------- framing ----------------
      send(0, {2'b00, 32'h1111_1111});
`ifdef OPTIMSOC_NOC_ECHO_CHECK_EN
      chk("bare_payload_err", proto_err, 1);
`else
      chk("bare_payload_noerr", proto_err, 0);
`endif
      chk("bare_payload_echo", out_flit, {2'b00, 32'h1111_1111});
      send(0, {2'b10, 32'h2222_2222});
      repeat (3) cyc();
      chk("frm_rx", rx_pkts, 7);
      chk("frm_tx", tx_pkts, 7);

      // ---------------- multi-valid error ----------------
      in_flit  = S1;
      in_valid = 3'b011;
      cyc();
      in_valid = '0;
      #1;
      chk("multi_err", proto_err, 1);
      chk("multi_nowrite", out_valid, 3'b000);
      chk("multi_rx", rx_pkts, 7);
      repeat (3) cyc();
      chk("multi_sticky", proto_err, 1);

      // ---------------- counter wrap ----------------
      rst = 1'b1;
      cyc();
      chk("rst2_in_ready", in_ready, 3'b000);
      rst = 1'b0;
      #1;
      chk("rst2_err", proto_err, 0);
      chk("rst2_rx", rx_pkts, 0);
      cyc();
      in_flit   = S3;
      in_valid  = 3'b001;
      out_ready = 3'b111;
      repeat (65535) cyc();
      chk("wrap_rx_ffff", rx_pkts, 16'hFFFF);
      chk("wrap_tx_fffe", tx_pkts, 16'hFFFE);
      chk("wrap_ready", in_ready, 3'b111);
      cyc();
      in_valid = '0;
      #1;
      chk("wrap_rx_0", rx_pkts, 16'h0000);
      chk("wrap_tx_ffff", tx_pkts, 16'hFFFF);
      cyc();
      chk("wrap_tx_0", tx_pkts, 16'h0000);
      chk("wrap_idle", out_valid, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/noc_echo_endpoint.md
# noc_echo_endpoint

Synthesizable NoC responder that terminates the tile-side NoC link of a compute tile: it consumes the flits the tile emits on `noc_out_*` and drives the return traffic on the tile's `noc_in_*`. Every received packet is buffered per virtual channel and sent back on the same VC with its header rewritten: the sender becomes the destination. Used in single-tile simulations and FPGA bring-up in place of a real NoC, so message-passing and DMA software paths can be exercised end-to-end.

## Interface
- `FLIT_WIDTH`, 34: 32 data bits plus 2 type bits; type is `flit[33:32]`.
- `VCHANNELS`, 3: number of virtual channels.
- `DEPTH`, 16: flits per VC FIFO; must be a power of two and at least 2.
- `ECHO_ID`, 1: tile ID written into the source field of echoed packets; 5 bits used.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_flit` in FLIT_WIDTH: flit from the tile's `noc_out_flit`.
- `in_valid` in VCHANNELS: per-VC valid from the tile.
- `in_ready` out VCHANNELS: per-VC ready to the tile.
- `out_flit` out FLIT_WIDTH: flit to the tile's `noc_in_flit`.
- `out_valid` out VCHANNELS: per-VC valid; at most one bit is set.
- `out_ready` in VCHANNELS: per-VC ready from the tile.
- `rx_pkts` out 16: count of last flits received, all VCs.
- `tx_pkts` out 16: count of last flits sent, all VCs.
- `proto_err` out 1: sticky protocol-error flag.

## Operation
- **Flit types:**
  - `01` head.
  - `00` payload.
  - `10` last.
  - `11` single (head and last in one flit).
- **Header fields** (head or single flit):
  - dest is `[31:27]`.
  - class is `[26:24]`.
  - src is `[23:19]`.
  - All other bits pass through unchanged.
- **Receive:**
  - `in_ready[v] = !full[v]`. There is no bypass, so a FIFO that is full and being read in the same cycle still shows ready low.
  - A flit on VC v is written when `in_valid[v] && in_ready[v]`.
  - If more than one `in_valid` bit is set in a cycle, nothing is written and `proto_err` is set.
- **Header rewrite:** applied at FIFO write time to head and single flits.
  - dest takes the old src.
  - src takes `ECHO_ID[4:0]`.
  - Payload and last flits are stored unchanged.
- **Transmit FSM:**
  - States are IDLE and LOCKED. The round-robin pointer `rr` resets to 0.
  - In IDLE, the block searches from `rr` upward, with wrap-around, for the first non-empty FIFO, locks to it, and enters LOCKED in the same cycle. `out_valid` can therefore rise in the first cycle a FIFO is non-empty.
  - In LOCKED on VC v:
    - `out_valid[v] = !empty[v]` and `out_flit` is the FIFO head.
    - A handshake pops the FIFO.
    - On the handshake of a last or single flit, the FSM returns to IDLE and sets `rr = (v+1) mod VCHANNELS`.
  - If the locked FIFO runs empty mid-packet, valid drops but the lock is held. Other VCs are never interleaved into a packet.
- **Counters:**
  - `rx_pkts` increments on a write of a last or single flit.
  - `tx_pkts` increments on a send of a last or single flit.
  - Both are 16-bit and wrap from 0xFFFF to 0.

## Timing
- **Reset values:** while `rst` is high and on the first cycle after release:
  - `in_ready` = 0.
  - `out_valid` = 0.
  - `out_flit` = 0.
  - Counters = 0.
  - `proto_err` = 0.
  - FIFOs empty, FSM in IDLE, `rr` = 0.
- **Latency:** `in_ready` goes to all-ones in the cycle after `rst` falls. A flit accepted at edge N is presented on `out_valid` from cycle N+1 when it is at the FIFO head. The minimum echo latency is 1 cycle.
- **Throughput:** one flit per cycle in and one flit per cycle out concurrently.
- **Handshakes:** `out_flit` and `out_valid` remain stable while valid and not ready.
- **Simultaneous write and read on one FIFO:** both take effect and the occupancy is unchanged.
- **Reset mid-packet:** buffered flits are discarded and the FSM unlocks. A partially echoed packet is truncated, and the bench must not check the link after such a truncation.
- **Buffering limit:** packets longer than `DEPTH` are legal, because transmit is cut-through and not store-and-forward.

## Configuration
- **`OPTIMSOC_NOC_ECHO_CHECK_EN` defined:** a per-VC in-packet bit tracks receive framing, and `proto_err` is also set for:
  - a payload or last flit arriving with no open packet;
  - a head or single flit arriving while a packet is open.
- Offending flits are still stored and echoed; the check is observational only.
- **`OPTIMSOC_NOC_ECHO_CHECK_EN` undefined:** no framing check is performed. `proto_err` reports only the multi-valid error.

## Test plan
- **Reset:**
  - Stimulus: `rst` high for 3 cycles, then low.
  - Required: `in_ready` = 0 during reset, 3'b111 one cycle after release; `out_valid` = 0 throughout.
- **Single-flit echo:**
  - Stimulus: flit `2'b11, 32'h0808_1234` on VC0, i.e. dest 1, class 0, src 1 with `ECHO_ID` = 1.
  - Required: the next cycle, `out_valid` = 3'b001 and `out_flit` = `2'b11, 32'h0808_1234`. Then, on an input of `2'b11, 32'h10F8_0000` (dest 2, class 0, src 31), the output is `2'b11, 32'hF808_0000`. `rx_pkts` = `tx_pkts` = 2 afterwards.
- **Back-pressure:**
  - Stimulus: hold `out_ready` = 0 and push 16 payload flits following a head on VC1.
  - Required: `in_ready[1]` drops after 16 flits are stored; no flit is lost or duplicated after `out_ready` is released.
- **Round-robin and lock:**
  - Stimulus: 3-flit packets pending on VC0 and VC2 simultaneously.
  - Required: VC0 is sent completely first with no VC2 flit in between, then VC2, and `rr` = 0 afterwards.
- **Errors:**
  - Stimulus: `in_valid` = 3'b011 for one cycle.
  - Required: no write occurs and `proto_err` = 1 and stays at 1.
  - Stimulus, with the macro defined: a bare payload flit on VC0.
  - Required: `proto_err` = 1.
- **Counter wrap:**
  - Stimulus: 65 536 single-flit packets.
  - Required: `rx_pkts` = `tx_pkts` = 0.
